// File: rtl/window_addr_gen.sv
// window_addr_gen: raster scan over an IMG_W x IMG_H output image that
// produces the nine 3x3 read addresses into the zero-padded
// (IMG_W+2) x (IMG_H+2) input buffer, plus the output write address.
// All addresses are registered and advanced with adders only, so no
// multipliers are needed.
// Optional build macro: WAG_BOUNDS_CHK_EN adds a sticky 'err' output that
// flags any out-of-range address seen while 'valid' is high.
module window_addr_gen #(
  parameter int unsigned IMG_W = 800,
  parameter int unsigned IMG_H = 600,
  parameter int unsigned AW    = 19
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stall,
  output logic [AW-1:0] a0,
  output logic [AW-1:0] a1,
  output logic [AW-1:0] a2,
  output logic [AW-1:0] a3,
  output logic [AW-1:0] a4,
  output logic [AW-1:0] a5,
  output logic [AW-1:0] a6,
  output logic [AW-1:0] a7,
  output logic [AW-1:0] a8,
  output logic [AW-1:0] ao,
  output logic          valid,
  output logic          busy,
  output logic          done
`ifdef WAG_BOUNDS_CHK_EN
  ,
  output logic          err
`endif
);

  localparam int unsigned PW = IMG_W + 2;
  localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   c_q;
  logic [RW-1:0]   r_q;
  logic [AW-1:0]   a_q [9];
  logic [AW-1:0]   ao_q;
  logic [AW-1:0]   step;
  logic            last_col;
  logic            last_pix;
  logic            adv;
  logic            reload;
  logic            start_acc;

  assign last_col = (c_q == CW'(IMG_W - 1));
  assign last_pix = last_col && (r_q == RW'(IMG_H - 1));
  // Moving off the last column also skips the two right/left pad columns.
  assign step     = last_col ? AW'(3) : AW'(1);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    adv       = 1'b0;
    reload    = 1'b0;
    start_acc = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          start_acc = 1'b1;
        end
      end
      RUN: begin
        if (!stall) begin
          if (last_pix) begin
            state_d = DONE;
            reload  = 1'b1;
          end else begin
            adv = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        reload  = 1'b1;
      end
      default: begin
        state_d = IDLE;
        reload  = 1'b1;
      end
    endcase
  end

  // Pixel counters and address registers; reload parks them on window (0,0).
  always_ff @(posedge clk) begin
    if (!reset || reload) begin
      c_q  <= '0;
      r_q  <= '0;
      ao_q <= '0;
      for (int unsigned k = 0; k < 9; k++) begin
        a_q[k] <= AW'((k / 3) * PW + (k % 3));
      end
    end else if (adv) begin
      if (last_col) begin
        c_q <= '0;
        r_q <= r_q + RW'(1);
      end else begin
        c_q <= c_q + CW'(1);
      end
      ao_q <= ao_q + AW'(1);
      for (int unsigned k = 0; k < 9; k++) begin
        a_q[k] <= a_q[k] + step;
      end
    end
  end

  assign a0    = a_q[0];
  assign a1    = a_q[1];
  assign a2    = a_q[2];
  assign a3    = a_q[3];
  assign a4    = a_q[4];
  assign a5    = a_q[5];
  assign a6    = a_q[6];
  assign a7    = a_q[7];
  assign a8    = a_q[8];
  assign ao    = ao_q;
  assign valid = (state_q == RUN);
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);

`ifdef WAG_BOUNDS_CHK_EN
  localparam logic [AW-1:0] A_MAX = AW'(PW * (IMG_H + 2) - 1);
  localparam logic [AW-1:0] O_MAX = AW'(IMG_W * IMG_H - 1);

  logic err_q;
  logic over;

  // Range comparators on the live window.
  always_comb begin
    over = (ao_q > O_MAX);
    for (int unsigned k = 0; k < 9; k++) begin
      if (a_q[k] > A_MAX) begin
        over = 1'b1;
      end
    end
  end

  // Sticky error flag, cleared when a new frame is accepted.
  always_ff @(posedge clk) begin
    if (!reset || start_acc) begin
      err_q <= 1'b0;
    end else if (valid && over) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`endif

endmodule
